axi4_lite_master: RTL



---
 rtl/axi4_lite_pkg.sv | 19 +
 rtl/axi4_lite_master.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_pkg.sv
// Types shared by the AXI4-Lite master and the 4-register AXI4-Lite slave.
// Response codes travel through the master unchanged, so both sides use resp_t.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        READ  = 2'b10,
        RESP  = 2'b11
    } state_t;

endpackage

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: one valid/ready command in, one AXI
// transaction out, result held on the response interface until taken.
module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_write_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic [1:0]            rsp_resp_o,
    output logic [ADDR_WIDTH-1:0] awaddr_o,
    output logic                  awvalid_o,
    input  logic                  awready_i,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  wvalid_o,
    input  logic                  wready_i,
    input  logic [1:0]            bresp_i,
    input  logic                  bvalid_i,
    output logic                  bready_o,
    output logic [ADDR_WIDTH-1:0] araddr_o,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic [1:0]            rresp_i,
    input  logic                  rvalid_i,
    output logic                  rready_o
);

    state_t                state_q, state_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  b_done_q, b_done_d;
    logic                  ar_done_q, ar_done_d;
    logic                  r_done_q, r_done_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    resp_t                 resp_q, resp_d;

    // Handshakes are derived from registered state so that no AXI input
    // reaches an AXI output combinationally.
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    assign aw_hs = (state_q == WRITE) && !aw_done_q && awready_i;
    assign w_hs  = (state_q == WRITE) && !w_done_q  && wready_i;
    assign b_hs  = (state_q == WRITE) && !b_done_q  && bvalid_i;
    assign ar_hs = (state_q == READ)  && !ar_done_q && arready_i;
    assign r_hs  = (state_q == READ)  && !r_done_q  && rvalid_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
            ar_done_q <= 1'b0;
            r_done_q  <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= OKAY;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            b_done_q  <= b_done_d;
            ar_done_q <= ar_done_d;
            r_done_q  <= r_done_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        b_done_d  = b_done_q;
        ar_done_d = ar_done_q;
        r_done_d  = r_done_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    write_d   = cmd_write_i;
                    addr_d    = cmd_addr_i;
                    wdata_d   = cmd_write_i ? cmd_wdata_i : '0;
                    rdata_d   = '0;
                    resp_d    = OKAY;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    b_done_d  = 1'b0;
                    ar_done_d = 1'b0;
                    r_done_d  = 1'b0;
                    state_d   = cmd_write_i ? WRITE : READ;
                end
            end
            WRITE: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q  | w_hs;
                b_done_d  = b_done_q  | b_hs;
                if (b_hs) begin
                    resp_d = resp_t'(bresp_i);
                end
                if (aw_done_d && w_done_d && b_done_d) begin
                    state_d = RESP;
                end
            end
            READ: begin
                ar_done_d = ar_done_q | ar_hs;
                r_done_d  = r_done_q  | r_hs;
                if (r_hs) begin
                    rdata_d = rdata_i;
                    resp_d  = resp_t'(rresp_i);
                end
                if (ar_done_d && r_done_d) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_o = (state_q == IDLE);
        awvalid_o   = (state_q == WRITE) && !aw_done_q;
        wvalid_o    = (state_q == WRITE) && !w_done_q;
        bready_o    = (state_q == WRITE) && !b_done_q;
        arvalid_o   = (state_q == READ)  && !ar_done_q;
        rready_o    = (state_q == READ)  && !r_done_q;
        rsp_valid_o = (state_q == RESP);
    end

    assign awaddr_o    = addr_q;
    assign araddr_o    = addr_q;
    assign wdata_o     = wdata_q;
    assign rsp_write_o = write_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_resp_o  = resp_q;

endmodule
